alu_share_ctrl: RTL and testbench

//   Shares one combinational 4-bit add/sub unit (enable/select/a/b -> result) between two requesters.
//   Per-requester req/done handshake; round-robin arbitration; operands latched at grant.

---
 rtl/alu_share_ctrl_pkg.sv | 22 ++
 rtl/alu_share_ctrl_if.sv | 39 +++
 rtl/alu_share_ctrl_rr_arb2.sv | 19 +
 rtl/alu_share_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_share_pkg
// Shared definitions for the two-requester add/sub sharing controller:
// FSM state encoding, operation codes and requester index constants.
// ----------------------------------------------------------------------------
package alu_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Value driven on the unit's select input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Requester indices (also the encoding of the one-bit winner register).
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl_if
// Bundles the requester handshake/operand bus and the link to the shared
// add/sub unit.
//   req[1:0], op[1:0], a0, b0, a1, b1 : requester side inputs
//   gnt[1:0], done[1:0], result, busy : requester side outputs
//   alu_enable, alu_select, alu_a/b   : controller -> add/sub unit
//   alu_result                        : add/sub unit -> controller
// Modports: slave = the controller, master = the surrounding logic.
// ----------------------------------------------------------------------------
interface alu_share_ctrl_if #(
    parameter int DATA_W = 4
);
    logic [1:0]        req;
    logic [1:0]        op;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              alu_enable;
    logic              alu_select;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;

    modport slave (
        input  req, op, a0, b0, a1, b1, alu_result,
        output gnt, done, result, busy, alu_enable, alu_select, alu_a, alu_b
    );

    modport master (
        output req, op, a0, b0, a1, b1, alu_result,
        input  gnt, done, result, busy, alu_enable, alu_select, alu_a, alu_b
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin arbiter.
//   req_i[1:0] : request vector
//   ptr_i      : requester favoured when both request
//   gnt_o[1:0] : one-hot grant (all zero when nobody requests)
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
// Shares one combinational add/sub unit between two requesters. A request
// seen in IDLE is arbitrated round-robin, the winner's op/operands are
// latched into the unit's inputs, the unit is driven for ALU_LAT cycles,
// its output is captured into result, and done is pulsed to the winner.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : alu_share_ctrl_if.slave (handshake, operands, unit link)
//   gnt_cnt0/1  : saturating grant counters (only with ALU_SHARE_STATS_EN)
// Optional feature macro: ALU_SHARE_STATS_EN.
// Timing: req sampled at edge n -> gnt high for the cycle after edge n,
// result valid after edge n+ALU_LAT, done high for the cycle after
// edge n+ALU_LAT+1 (which is an IDLE cycle; the next arbitration
// happens at the end of it).
// ----------------------------------------------------------------------------
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);
    localparam int EXEC_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_e              state_q, state_d;
    logic                winner_q, winner_d;
    logic                ptr_q, ptr_d;
    logic [EXEC_W-1:0]   exec_cnt_q, exec_cnt_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                en_q, en_d;
    logic                sel_q, sel_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [1:0]          arb_gnt;

    rr_arb2 u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        // NOTE: every _d gets its hold/default value first, so no path through
        // the case statement leaves a signal unassigned (no latches).
        state_d    = state_q;
        winner_d   = winner_q;
        ptr_d      = ptr_q;
        exec_cnt_d = exec_cnt_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        result_d   = result_q;
        en_d       = en_q;
        sel_d      = sel_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    winner_d   = arb_gnt[1];
                    sel_d      = arb_gnt[1] ? bus.op[1] : bus.op[0];
                    alu_a_d    = arb_gnt[1] ? bus.a1 : bus.a0;
                    alu_b_d    = arb_gnt[1] ? bus.b1 : bus.b0;
                    en_d       = 1'b1;
                    gnt_d      = arb_gnt;
                    exec_cnt_d = '0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_cnt_q == EXEC_W'(ALU_LAT - 1)) begin
                    result_d = bus.alu_result;
                    en_d     = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    exec_cnt_d = exec_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = (winner_q == REQ1) ? 2'b10 : 2'b01;
                ptr_d   = ~winner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            winner_q   <= REQ0;
            ptr_q      <= REQ0;
            exec_cnt_q <= '0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
            result_q   <= '0;
            en_q       <= 1'b0;
            sel_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            winner_q   <= winner_d;
            ptr_q      <= ptr_d;
            exec_cnt_q <= exec_cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            result_q   <= result_d;
            en_q       <= en_d;
            sel_q      <= sel_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.result     = result_q;
    assign bus.alu_enable = en_q;
    assign bus.alu_select = sel_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;

`ifdef ALU_SHARE_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt_d[0] && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
            if (gnt_d[1] && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
// Drives alu_share_ctrl together with a behavioural add/sub unit. A
// transaction-level reference (last accepted op + its start edge) predicts
// every output for every cycle; directed sequences pin the reference with
// hand-computed values, then randomized requesters exercise the block.
// Build with ALU_SHARE_STATS_EN defined to also check the grant counters.
// ----------------------------------------------------------------------------
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int DATA_W  = 4;
    localparam int ALU_LAT = 1;
    localparam int CNT_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.DATA_W(DATA_W)) bus ();

`ifdef ALU_SHARE_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

    alu_share_ctrl #(
        .DATA_W  (DATA_W),
        .ALU_LAT (ALU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef ALU_SHARE_STATS_EN
        ,
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
`endif
    );

    // Shared add/sub unit: all ones while disabled.
    assign bus.alu_result = !bus.alu_enable ? '1 :
                            (bus.alu_select == OP_SUB) ? bus.alu_a - bus.alu_b
                                                       : bus.alu_a + bus.alu_b;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              e;        // rising edges since reset
    int              s;        // edge at which the last op was accepted
    bit              have_op;
    bit              mw;
    logic            msel;
    logic [3:0]      ma, mb, mr, mprev;
    bit              mptr;
    int              mcnt [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0; s = 0; have_op = 0; mw = 0; msel = 0;
            ma = 0; mb = 0; mr = 0; mprev = 0; mptr = 0;
            mcnt[0] = 0; mcnt[1] = 0;
        end else begin
            e++;
            // Free again ALU_LAT+2 edges after the previous acceptance.
            if ((!have_op || (e - s) >= ALU_LAT + 2) && bus.req != 2'b00) begin
                if (have_op) mprev = mr;
                mw   = (bus.req == 2'b11) ? mptr : bus.req[1];
                msel = bus.op[mw];
                ma   = mw ? bus.a1 : bus.a0;
                mb   = mw ? bus.b1 : bus.b0;
                mr   = msel ? ma - mb : ma + mb;
                s    = e;
                have_op = 1;
                mptr = !mw;
                if (mcnt[mw] < (1 << CNT_W) - 1) mcnt[mw]++;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        int         d;
        logic [1:0] onehot, eg, ed;
        if (rst_n) begin
            d      = e - s;
            onehot = mw ? 2'b10 : 2'b01;
            eg     = (have_op && d == 0) ? onehot : 2'b00;
            ed     = (have_op && d == ALU_LAT + 1) ? onehot : 2'b00;
            check("gnt",        bus.gnt,        eg);
            check("done",       bus.done,       ed);
            check("busy",       bus.busy,       have_op && d <= ALU_LAT);
            check("alu_enable", bus.alu_enable, have_op && d < ALU_LAT);
            check("alu_select", bus.alu_select, msel);
            check("alu_a",      bus.alu_a,      ma);
            check("alu_b",      bus.alu_b,      mb);
            check("result",     bus.result,     (have_op && d >= ALU_LAT) ? mr : mprev);
`ifdef ALU_SHARE_STATS_EN
            check("gnt_cnt0",   gnt_cnt0,       mcnt[0]);
            check("gnt_cnt1",   gnt_cnt1,       mcnt[1]);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req = 2'b00; bus.op = 2'b00;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    endtask

    task automatic set_req(input int i, input logic o, input logic [3:0] a, input logic [3:0] b);
        bus.req[i] = 1'b1;
        bus.op[i]  = o;
        if (i == 0) begin bus.a0 = a; bus.b0 = b; end
        else        begin bus.a1 = a; bus.b1 = b; end
    endtask

    // Issue one op and report latencies (edges to gnt / done) and result.
    task automatic do_op(input int i, input logic o, input logic [3:0] a, input logic [3:0] b,
                         output int lg, output int ld, output logic [3:0] res);
        lg = -1; ld = -1; res = 'x;
        set_req(i, o, a, b);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.gnt[i] && lg < 0) lg = k;
            if (bus.done[i]) begin ld = k; res = bus.result; break; end
        end
        bus.req[i] = 1'b0;
        if (ld < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: requester %0d got no done within 20 cycles", i);
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    bit         pend [2];
    bit         granted [2];
    int         lg, ld;
    logic [3:0] res;

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   bus.busy,       1'b0);
        check("rst_result", bus.result,     4'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single add 3+4.
        do_op(0, OP_ADD, 4'd3, 4'd4, lg, ld, res);
        check("add_gnt_lat",  lg,  1);
        check("add_done_lat", ld,  3);
        check("add_result",   res, 4'd7);

        // Subtract with wrap, then add with wrap.
        do_op(1, OP_SUB, 4'd2, 4'd5, lg, ld, res);
        check("sub_wrap_result", res, 4'hD);
        do_op(1, OP_ADD, 4'd9, 4'd9, lg, ld, res);
        check("add_wrap_result", res, 4'h2);

        // Operand change and req drop after grant are ignored.
        set_req(0, OP_ADD, 4'd5, 4'd6);
        tick();
        check("stab_gnt", bus.gnt, 2'b01);
        bus.a0 = 4'hF; bus.req[0] = 1'b0;
        tick();
        tick();
        check("stab_done",   bus.done,   2'b01);
        check("stab_result", bus.result, 4'hB);

        // Reset in the middle of EXEC.
        tick();
        set_req(0, OP_SUB, 4'd7, 4'd1);
        tick();
        check("mid_gnt", bus.gnt, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt",    bus.gnt,        2'b00);
        check("mid_rst_busy",   bus.busy,       1'b0);
        check("mid_rst_enable", bus.alu_enable, 1'b0);
        check("mid_rst_alu_a",  bus.alu_a,      4'h0);
        check("mid_rst_result", bus.result,     4'h0);
        clear_inputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_done", bus.done, 2'b00);
        end

        // Contention from reset: 0,1,0,1 each with its own result.
        #2 rst_n = 1'b0;
        set_req(0, OP_ADD, 4'd1, 4'd1);
        set_req(1, OP_SUB, 4'd8, 4'd3);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            int lim;
            lim = 0;
            while (bus.gnt == 2'b00 && lim < 10) begin tick(); lim++; end
            check("rr_gnt", bus.gnt, (g % 2 == 1) ? 2'b10 : 2'b01);
            lim = 0;
            while (bus.done == 2'b00 && lim < 10) begin tick(); lim++; end
            check("rr_done",   bus.done,   (g % 2 == 1) ? 2'b10 : 2'b01);
            check("rr_result", bus.result, (g % 2 == 1) ? 4'd5 : 4'd2);
        end
        pulse_reset();

        // Randomized requesters.
        pend[0] = 0; pend[1] = 0; granted[0] = 0; granted[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
                pend[0] = 0; pend[1] = 0; granted[0] = 0; granted[1] = 0;
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    if (bus.done[i]) begin
                        pend[i] = 0; granted[i] = 0;
                        if ($urandom_range(0, 1) == 1) begin
                            set_req(i, 1'($urandom), 4'($urandom), 4'($urandom));
                            pend[i] = 1;
                        end else begin
                            bus.req[i] = 1'b0;
                        end
                    end else if (bus.gnt[i]) begin
                        granted[i] = 1;
                        if ($urandom_range(0, 3) == 0) bus.req[i] = 1'b0;
                    end else if (granted[i] && $urandom_range(0, 1) == 1) begin
                        bus.op[i] = 1'($urandom);
                        if (i == 0) bus.a0 = 4'($urandom); else bus.a1 = 4'($urandom);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom), 4'($urandom), 4'($urandom));
                    pend[i] = 1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
